shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Sequential 8-bit right shifter for the ALU datapath, the right-shift counterpart of the combinational left shifter. It accepts an operand and a 4-bit shift amount on a start pulse and shifts one bit position per clock, either logically (zero fill) or arithmetically (sign fill). It then presents the result and the last bit shifted out with a one-cycle done pulse. Its start/busy/done handshake lets the ALU controller sequence it like the other multi-cycle units.

## Interface
- `WIDTH`, 8: operand/result width.
- `SHW`, 4: shift-amount width. The maximum shift is 2^SHW − 1 = 15.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  : request. Accepted only in IDLE.
- `A`  in  WIDTH  : operand, sampled on the accepting edge.
- `Shift`  in  SHW  : shift amount 0..15, sampled on the accepting edge.
- `Arith`  in  1  : 1 = arithmetic (sign fill), 0 = logical (zero fill). Sampled on the accepting edge.
- `busy`  out  1  : high whenever the state is not IDLE.
- `done`  out  1  : one-cycle pulse; result is valid.
- `ASR`  out  WIDTH  : result, held from `done` until the next `done`.
- `Carry`  out  1  : last bit shifted out of bit 0. It is 0 when `Shift` = 0.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `start` = 1: load the work register with `A`, the counter with `Shift`, and the fill bit (`Arith` ? `A[WIDTH-1]` : 0). Clear the working carry.
  - Next state is SHIFT if `Shift` ≠ 0, otherwise DONE.
- **SHIFT, each cycle:**
  - work ← {fill, work[WIDTH-1:1]}
  - working carry ← work[0]
  - counter ← counter − 1
  - When the counter equals 1 before the decrement, next state is DONE.
- **DONE, one cycle:**
  - `done` = 1.
  - `ASR` ← work and `Carry` ← working carry; both are registered on entry to DONE, so they are valid in the same cycle `done` is high.
  - Next state is IDLE unconditionally. `start` is ignored in DONE.
- **Shifts ≥ WIDTH:**
  - Logical: the result is 0. `Carry` is 0 for Shift ≥ 9 and A[7] for Shift = 8.
  - Arithmetic: the result is all copies of the sign bit, and `Carry` equals the sign bit.
  - Both fall out of the serial shift; there is no special-case logic.
- **Input changes:** `A`, `Shift` and `Arith` may change freely after acceptance; only the values latched at acceptance matter.
- **Start while busy:** `start` while `busy` = 1 is dropped. It is not queued.

## Timing
- **Reset** (`rst_n` = 0 at an edge): state = IDLE, `busy` = 0, `done` = 0, `ASR` = 0, `Carry` = 0, counter = 0.
  - Reset overrides everything, including mid-SHIFT and the DONE cycle.
  - An operation aborted by reset never produces `done`.
- **Latency:** let `start` be accepted at edge k.
  - `done` is high during the cycle following edge k + Shift + 1 − 1, i.e. Shift + 1 edges after acceptance.
  - Shift = 0 gives `done` in the cycle right after acceptance.
  - Shift = 15 gives `done` 16 cycles after acceptance.
- **Busy:** `busy` rises in the cycle after acceptance and stays high through the DONE cycle.
- **Back-to-back throughput:** the earliest next acceptance is the cycle after DONE (IDLE), giving one operation per Shift + 2 cycles.
- **Outputs:** all outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `alu_pkg`:**
  - `ALU_WIDTH` = 8 and `SHIFT_W` = 4 constants.
  - `shr_state_t` enum {IDLE, SHIFT, DONE}.
- **Single module, no sub-module.**
  - Contents: one state register, a SHW-bit down-counter, the work register, the fill bit and the working carry.
  - The logic is too small to justify splitting out the counter.

## Test plan
- A=0x96, Shift=3, Arith=0, start one cycle → `done` 4 cycles later, ASR=0x12, Carry=1, `busy` high 4 cycles.
- A=0x96, Shift=3, Arith=1 → ASR=0xF2, Carry=1, same latency.
- A=0x5A, Shift=0 → `done` in the next cycle, ASR=0x5A, Carry=0.
- A=0x80, Shift=15: Arith=1 → ASR=0xFF, Carry=1, `done` after 16 cycles. Arith=0 → ASR=0x00, Carry=0.
- A=0x3C, Shift=5 started; at the 2nd busy cycle pulse `start` with A=0xFF, Shift=1 → exactly one `done`, ASR=0x01, Carry=1. Then a new start in IDLE is accepted normally.
- Start A=0xF0, Shift=6; drive `rst_n` low for one edge during SHIFT → next cycle busy=0, done=0, ASR=0, Carry=0, and no `done` ever appears for that operation.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default operand/shift widths and the
// state encoding for the sequential right shifter.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int SHIFT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

endpackage : alu_pkg

// File: rtl/shift_right_seq.sv
// Sequential right shifter: takes an operand and a shift amount on a start
// pulse, shifts one position per clock with zero or sign fill, and presents
// the result plus the last bit shifted out alongside a one-cycle done pulse.
module shift_right_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = SHIFT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   Shift,
    input  logic             Arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ASR,
    output logic             Carry
);

    shr_state_t       state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] work;
    logic             fill;
    logic             work_carry;

    // Next value of the work register for one serial shift step; the bit
    // leaving position 0 becomes the working carry.
    logic [WIDTH-1:0] work_shifted;
    assign work_shifted = {fill, work[WIDTH-1:1]};

    // Control FSM and datapath: load on accept, shift once per cycle, and
    // register the result/carry on the edge that enters DONE so they line up
    // with the done pulse. Shifts >= WIDTH need no special case: the fill bit
    // simply keeps streaming in.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked
        // block with no rst_n in the sensitivity list; every register,
        // including the datapath, is cleared so state after reset is known.
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            work       <= '0;
            fill       <= 1'b0;
            work_carry <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ASR        <= '0;
            Carry      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side sees the value from before this edge (e.g. work[0] below is
            // the pre-shift bit, not the freshly shifted one).
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work       <= A;
                        count      <= Shift;
                        fill       <= Arith & A[WIDTH-1];
                        work_carry <= 1'b0;
                        busy       <= 1'b1;
                        if (Shift == '0) begin
                            // Zero shift: result is the operand, carry is 0.
                            state <= DONE;
                            done  <= 1'b1;
                            ASR   <= A;
                            Carry <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work       <= work_shifted;
                    work_carry <= work[0];
                    count      <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        ASR   <= work_shifted;
                        Carry <= work[0];
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; ASR/Carry hold.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_right_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [3:0] Shift;
    logic       Arith;
    logic       busy;
    logic       done;
    logic [7:0] ASR;
    logic       Carry;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    shift_right_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .Shift (Shift),
        .Arith (Arith),
        .busy  (busy),
        .done  (done),
        .ASR   (ASR),
        .Carry (Carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry, result} of shifting a right by sh positions.
    function automatic logic [8:0] model(input logic [7:0] a, input int sh,
                                         input logic ar);
        logic       sign;
        logic [7:0] res;
        logic       cy;
        sign = ar & a[7];
        if (sh == 0) begin
            res = a;
            cy  = 1'b0;
        end else if (sh >= 8) begin
            res = {8{sign}};
            cy  = (sh == 8) ? a[7] : sign;
        end else begin
            res = ar ? 8'($signed(a) >>> sh) : (a >> sh);
            cy  = a[sh-1];
        end
        return {cy, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start with (a, sh, ar); optionally pulse a second start
    // during the busy cycle numbered inj (0 = first busy cycle).
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [3:0] sh, input logic ar, input int inj);
        logic [8:0] exp;
        int dcount;
        int done_at;
        exp     = model(a, int'(sh), ar);
        dcount  = 0;
        done_at = -1;
        @(negedge clk);
        start = 1'b1; A = a; Shift = sh; Arith = ar;
        @(posedge clk); #1;
        for (int j = 0; j <= int'(sh) + 1; j++) begin
            if (done === 1'b1) begin
                dcount++;
                if (done_at < 0) done_at = j;
            end
            check({tag, " busy"}, 32'(busy), 32'(j <= int'(sh)));
            if (j == int'(sh)) begin
                check({tag, " ASR"}, 32'(ASR), 32'(exp[7:0]));
                check({tag, " Carry"}, 32'(Carry), 32'(exp[8]));
            end
            @(negedge clk);
            if (j == inj) begin
                start = 1'b1; A = 8'hFF; Shift = 4'd1; Arith = 1'b0;
            end else begin
                start = 1'b0;
                A = 8'($urandom); Shift = 4'($urandom); Arith = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (done === 1'b1) dcount++;
            @(posedge clk); #1;
        end
        check({tag, " done count"}, 32'(dcount), 32'd1);
        check({tag, " done latency"}, 32'(done_at), 32'(sh));
        check({tag, " ASR held"}, 32'(ASR), 32'(exp[7:0]));
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; start = 1'b0; A = '0; Shift = '0; Arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ASR", 32'(ASR), 32'd0);
        check("reset Carry", 32'(Carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("lsr96_3", 8'h96, 4'd3, 1'b0, -1);
        run_op("asr96_3", 8'h96, 4'd3, 1'b1, -1);
        run_op("sh0", 8'h5A, 4'd0, 1'b0, -1);
        run_op("asr80_15", 8'h80, 4'd15, 1'b1, -1);
        run_op("lsr80_15", 8'h80, 4'd15, 1'b0, -1);
        run_op("lsr_sh8", 8'hA5, 4'd8, 1'b0, -1);
        run_op("lsr_sh9", 8'hFF, 4'd9, 1'b0, -1);
        run_op("drop_start", 8'h3C, 4'd5, 1'b0, 1);
        run_op("after_drop", 8'hC3, 4'd2, 1'b1, -1);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 8'($urandom), 4'($urandom), 1'($urandom), -1);
        end

        // Reset in the middle of a shift aborts the operation.
        @(negedge clk);
        start = 1'b1; A = 8'hF0; Shift = 4'd6; Arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort ASR", 32'(ASR), 32'd0);
        check("abort Carry", 32'(Carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);

        run_op("post_reset", 8'h81, 4'd1, 1'b1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_shift_right_seq
